// File: rtl/morse_key_classifier.sv
// Morse key front end: sync, debounce, press timing and word-gap detection.
// Define MORSE_ABORT_EN to let a very long press cancel the current word.
module morse_key_classifier #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DOT_MAX_CYCLES  = 12500000,
  parameter int GAP_CYCLES      = 37500000,
  parameter int MAX_SYMBOLS     = 5,
  parameter int ABORT_CYCLES    = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       user_input,
  output logic       ld_dot,
  output logic       ld_line,
  output logic       word_done,
  output logic [2:0] symbol_count,
  output logic       key_clean
);

`ifdef MORSE_ABORT_EN
  localparam int PRESS_SAT = ABORT_CYCLES;
`else
  localparam int PRESS_SAT = DOT_MAX_CYCLES;
`endif
  localparam int PW  = $clog2(PRESS_SAT + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PW-1:0]  PRESS_MAX = PW'(PRESS_SAT);
  localparam logic [PW-1:0]  DOT_V     = PW'(DOT_MAX_CYCLES);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]     SYM_LAST  = 3'(MAX_SYMBOLS - 1);

  // An abort threshold at or below the dot limit could never be told apart from a line.
  if (ABORT_CYCLES <= DOT_MAX_CYCLES) begin : g_bad_abort
    $error("ABORT_CYCLES must exceed DOT_MAX_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, PRESS, GAP, FULL} state_t;

  state_t         state, state_n;
  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt;
  logic           key_clean_q;
  logic [PW-1:0]  press_cnt, press_n;
  logic [GW-1:0]  gap_cnt, gap_n;
  logic [2:0]     sym_n;
  logic           dot_n, line_n, done_n;
  logic           kc_rise, kc_fall, aborted;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      db_cnt      <= '0;
      key_clean   <= 1'b0;
      key_clean_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], user_input};
      key_clean_q <= key_clean;
      if (sync_q[1] == key_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_clean <= ~key_clean;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Edge-based start so a key already held when enable rises is ignored.
  assign kc_rise = key_clean & ~key_clean_q;
  assign kc_fall = ~key_clean & key_clean_q;

`ifdef MORSE_ABORT_EN
  assign aborted = (press_cnt == PRESS_MAX);
`else
  assign aborted = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      press_cnt    <= '0;
      gap_cnt      <= '0;
      symbol_count <= '0;
      ld_dot       <= 1'b0;
      ld_line      <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      state        <= state_n;
      press_cnt    <= press_n;
      gap_cnt      <= gap_n;
      symbol_count <= sym_n;
      ld_dot       <= dot_n;
      ld_line      <= line_n;
      word_done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    press_n = press_cnt;
    gap_n   = gap_cnt;
    sym_n   = symbol_count;
    dot_n   = 1'b0;
    line_n  = 1'b0;
    done_n  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      press_n = '0;
      gap_n   = '0;
      sym_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (kc_rise) begin
            state_n = PRESS;
            press_n = '0;
          end
        end
        PRESS: begin
          if (press_cnt != PRESS_MAX) press_n = press_cnt + 1'b1;
          if (aborted) sym_n = '0;
          if (kc_fall) begin
            if (aborted) begin
              state_n = IDLE;
            end else begin
              dot_n   = (press_cnt < DOT_V);
              line_n  = ~dot_n;
              sym_n   = symbol_count + 3'd1;
              gap_n   = '0;
              state_n = (symbol_count == SYM_LAST) ? FULL : GAP;
            end
          end
        end
        GAP: begin
          if (kc_rise) begin
            state_n = PRESS;
            press_n = '0;
            gap_n   = '0;
          end else if (gap_cnt == GAP_LAST) begin
            done_n  = 1'b1;
            sym_n   = '0;
            gap_n   = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        FULL: begin
          // Word is full: presses only hold off the timeout.
          if (key_clean) begin
            gap_n = '0;
          end else if (gap_cnt == GAP_LAST) begin
            done_n  = 1'b1;
            sym_n   = '0;
            gap_n   = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with shortened timing parameters.
module tb_morse_key_classifier;
  logic       clock, reset, enable, user_input;
  logic       ld_dot, ld_line, word_done, key_clean;
  logic [2:0] symbol_count;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_dot = 0, n_line = 0, n_done = 0, n_rise = 0, n_excl = 0;
  int dot_cyc = 0, done_cyc = 0;
  logic kc_prev = 1'b0;
  int ev_q[$];
  int sc_q[$];
  int b_dot, b_line, b_done, b_rise, qb;
  int exp_ev[3] = '{2, 1, 2};
  int exp_sc[3] = '{1, 2, 3};

  morse_key_classifier #(
    .DEBOUNCE_CYCLES(4), .DOT_MAX_CYCLES(20), .GAP_CYCLES(50),
    .MAX_SYMBOLS(5), .ABORT_CYCLES(200)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .user_input(user_input),
    .ld_dot(ld_dot), .ld_line(ld_line), .word_done(word_done),
    .symbol_count(symbol_count), .key_clean(key_clean)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ld_dot) begin n_dot++; ev_q.push_back(1); sc_q.push_back(int'(symbol_count)); dot_cyc = cyc; end
    if (ld_line) begin n_line++; ev_q.push_back(2); sc_q.push_back(int'(symbol_count)); end
    if (word_done) begin n_done++; done_cyc = cyc; end
    if (int'(ld_dot) + int'(ld_line) + int'(word_done) > 1) n_excl++;
    if (key_clean && !kc_prev) n_rise++;
    kc_prev = key_clean;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic key(input int on_c, input int off_c);
    user_input = 1'b1;
    repeat (on_c) @(posedge clock);
    #1 user_input = 1'b0;
    repeat (off_c) @(posedge clock);
    #1;
  endtask

  task automatic snap();
    b_dot = n_dot; b_line = n_line; b_done = n_done; b_rise = n_rise; qb = ev_q.size();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; user_input = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst key_clean", key_clean, 0);
    chk("rst symbol_count", symbol_count, 0);
    chk("rst pulses", {ld_dot, ld_line, word_done}, 0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    // single dot, debounce latency and gap timeout
    snap();
    user_input = 1'b1;
    repeat (5) @(posedge clock);
    #1 chk("t1 kc before 6", key_clean, 0);
    @(posedge clock);
    #1 chk("t1 kc at 6", key_clean, 1);
    repeat (4) @(posedge clock);
    #1 user_input = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("t1 dots", n_dot - b_dot, 1);
    chk("t1 lines", n_line - b_line, 0);
    chk("t1 sc", symbol_count, 1);
    repeat (60) @(posedge clock);
    #1;
    chk("t1 done", n_done - b_done, 1);
    chk("t1 gap len", done_cyc - dot_cyc, 50);
    chk("t1 sc clr", symbol_count, 0);

    // line, dot, line
    snap();
    key(40, 20); key(10, 20); key(40, 20);
    chk("t2 nev", ev_q.size() - qb, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2 ev%0d", i), (qb + i < ev_q.size()) ? ev_q[qb + i] : 0, exp_ev[i]);
      chk($sformatf("t2 sc%0d", i), (qb + i < sc_q.size()) ? sc_q[qb + i] : 0, exp_sc[i]);
    end
    chk("t2 no early done", n_done - b_done, 0);
    repeat (80) @(posedge clock);
    #1 chk("t2 done", n_done - b_done, 1);

    // glitches are filtered
    snap();
    for (int i = 0; i < 30; i++) begin
      user_input = 1'b1;
      @(posedge clock);
      #1 user_input = 1'b0;
      repeat (2) @(posedge clock);
      #1;
    end
    repeat (20) @(posedge clock);
    #1;
    chk("t3 kc rises", n_rise - b_rise, 0);
    chk("t3 pulses", (n_dot - b_dot) + (n_line - b_line) + (n_done - b_done), 0);

    // symbol limit
    snap();
    for (int i = 0; i < 6; i++) key(10, 20);
    chk("t4 dots", n_dot - b_dot, 5);
    chk("t4 lines", n_line - b_line, 0);
    chk("t4 sc full", symbol_count, 5);
    chk("t4 no early done", n_done - b_done, 0);
    repeat (80) @(posedge clock);
    #1;
    chk("t4 done", n_done - b_done, 1);
    chk("t4 sc clr", symbol_count, 0);

    // enable dropped mid-press
    key(10, 20);
    chk("t5 pre sc", symbol_count, 1);
    snap();
    user_input = 1'b1;
    repeat (15) @(posedge clock);
    #1 enable = 1'b0;
    repeat (5) @(posedge clock);
    #1 enable = 1'b1;
    repeat (10) @(posedge clock);
    #1 user_input = 1'b0;
    repeat (80) @(posedge clock);
    #1;
    chk("t5 pulses", (n_dot - b_dot) + (n_line - b_line), 0);
    chk("t5 done", n_done - b_done, 0);
    chk("t5 sc", symbol_count, 0);

    // reset mid-press
    key(10, 20);
    chk("t5r pre sc", symbol_count, 1);
    snap();
    user_input = 1'b1;
    repeat (15) @(posedge clock);
    #1 reset = 1'b1;
    #2;
    chk("t5r kc", key_clean, 0);
    chk("t5r sc", symbol_count, 0);
    chk("t5r pulses", {ld_dot, ld_line, word_done}, 0);
    user_input = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (80) @(posedge clock);
    #1;
    chk("t5r no pulses", (n_dot - b_dot) + (n_line - b_line) + (n_done - b_done), 0);

    // two dots then a very long press
    snap();
    key(10, 20); key(10, 20); key(250, 20);
    chk("t6 dots", n_dot - b_dot, 2);
`ifdef MORSE_ABORT_EN
    chk("t6 lines", n_line - b_line, 0);
    chk("t6 sc", symbol_count, 0);
    repeat (80) @(posedge clock);
    #1 chk("t6 done", n_done - b_done, 0);
`else
    chk("t6 lines", n_line - b_line, 1);
    chk("t6 sc", symbol_count, 3);
    repeat (80) @(posedge clock);
    #1 chk("t6 done", n_done - b_done, 1);
`endif

    chk("exclusive pulses", n_excl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
